ifu_inst_buffer: RTL and testbench

- Instruction buffer at the IF→ID boundary.
- Accepts fetched instruction words, their addresses and branch-prediction tags from the fetch unit, and queues them in a small FIFO.
- Presents the head entry to the decode unit on inst/inst_addr/is_pred_branch.
- Holds the head entry under the ctrl stall bus, and drops all contents on a pipeline flush (branch redirect, trap).

---
 rtl/ifu_inst_buffer.sv | 123 ++++++++++++
 tb/tb_ifu_inst_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_buffer.sv
// Instruction buffer between fetch and decode: a small FIFO of {inst, addr, pred}
// with stall hold and flush. Define IBUF_BYPASS_EN for zero-latency empty bypass.

`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 6
`endif

module ifu_inst_buffer #(
  parameter int unsigned                 DEPTH     = 4,
  parameter int unsigned                 STALL_BIT = 1,
  parameter logic [`INST_DATA_WIDTH-1:0] NOP_INST  = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_valid_i,
  output logic                        fetch_ready_o,
  input  logic [`INST_DATA_WIDTH-1:0] fetch_inst_i,
  input  logic [`INST_ADDR_WIDTH-1:0] fetch_addr_i,
  input  logic                        fetch_pred_branch_i,
  input  logic                        flush_i,
  input  logic [`CU_BUS_WIDTH-1:0]    stall_flag_i,
  output logic                        inst_valid_o,
  output logic [`INST_DATA_WIDTH-1:0] inst_o,
  output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                        is_pred_branch_o
);

  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [`INST_DATA_WIDTH-1:0] inst;
    logic [`INST_ADDR_WIDTH-1:0] addr;
    logic                        pred;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             stall;
  logic             empty;
  logic             push;
  logic             pop;
  logic             unused_stall_bits;

  assign stall             = stall_flag_i[STALL_BIT];
  assign unused_stall_bits = ^stall_flag_i;
  assign empty             = (count == '0);
  assign head              = mem[rd_ptr];

  // Ready depends only on the occupancy register, so a full buffer refuses
  // a push even when decode pops in the same cycle.
  assign fetch_ready_o = (count != FULL);
  assign pop           = ~empty & ~stall & ~flush_i;

`ifdef IBUF_BYPASS_EN
  logic bypass;
  assign bypass = empty & fetch_valid_i & ~flush_i;
  // An unstalled bypass hands the word straight to decode, so it never lands in storage.
  assign push   = fetch_valid_i & fetch_ready_o & ~flush_i & ~(bypass & ~stall);
`else
  assign push   = fetch_valid_i & fetch_ready_o & ~flush_i;
`endif

  always_comb begin
    inst_valid_o     = 1'b0;
    inst_o           = NOP_INST;
    inst_addr_o      = '0;
    is_pred_branch_o = 1'b0;
    if (!empty) begin
      inst_valid_o     = 1'b1;
      inst_o           = head.inst;
      inst_addr_o      = head.addr;
      is_pred_branch_o = head.pred;
    end
`ifdef IBUF_BYPASS_EN
    else if (bypass) begin
      inst_valid_o     = 1'b1;
      inst_o           = fetch_inst_i;
      inst_addr_o      = fetch_addr_i;
      is_pred_branch_o = fetch_pred_branch_i;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read while count says they
  // were written, so resetting the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: fetch_inst_i, addr: fetch_addr_i, pred: fetch_pred_branch_i};
  end

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Directed bench for ifu_inst_buffer (default build): vector table plus
// wrap-around stream and mid-cycle asynchronous reset sequences.

`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 6
`endif

module tb_ifu_inst_buffer;

  typedef logic [`CU_BUS_WIDTH-1:0] stall_t;
  localparam stall_t      NS = '0;
  localparam stall_t      ST = stall_t'(2);
  localparam stall_t      OT = ~ST;
  localparam logic [31:0] N  = 32'h00000013;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        fetch_valid;
  logic                        fetch_ready;
  logic [`INST_DATA_WIDTH-1:0] fetch_inst;
  logic [`INST_ADDR_WIDTH-1:0] fetch_addr;
  logic                        fetch_pred;
  logic                        flush;
  stall_t                      stall_flag;
  logic                        inst_valid;
  logic [`INST_DATA_WIDTH-1:0] inst;
  logic [`INST_ADDR_WIDTH-1:0] inst_addr;
  logic                        is_pred_branch;

  int checks = 0;
  int errors = 0;

  ifu_inst_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_valid_i       (fetch_valid),
    .fetch_ready_o       (fetch_ready),
    .fetch_inst_i        (fetch_inst),
    .fetch_addr_i        (fetch_addr),
    .fetch_pred_branch_i (fetch_pred),
    .flush_i             (flush),
    .stall_flag_i        (stall_flag),
    .inst_valid_o        (inst_valid),
    .inst_o              (inst),
    .inst_addr_o         (inst_addr),
    .is_pred_branch_o    (is_pred_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
    logic        flush;
    stall_t      stall;
    logic [66:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
  } ent_t;

  vec_t vecs[$];

  function automatic logic [66:0] observed();
    return {fetch_ready, inst_valid, inst, inst_addr, is_pred_branch};
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {rdy,vld,inst,addr,pred}=%h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] i, input logic [31:0] a, input logic p,
                     input logic fl, input stall_t st, input logic r, input logic v,
                     input logic [31:0] ei, input logic [31:0] ea, input logic ep);
    vec_t t;
    t.fv = fv; t.inst = i; t.addr = a; t.pred = p; t.flush = fl; t.stall = st;
    t.exp = {r, v, ei, ea, ep};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic fv, input logic [31:0] i, input logic [31:0] a,
                       input logic p, input logic fl, input stall_t st);
    fetch_valid = fv; fetch_inst = i; fetch_addr = a; fetch_pred = p; flush = fl; stall_flag = st;
  endtask

  initial begin
    ent_t q[$];
    ent_t nxt;
    ent_t hd;
    logic [66:0] exp;
    logic push_m, pop_m;
    int sent;

    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0, NS);
    repeat (2) @(negedge clk);
    check("reset_hold", observed(), {1'b1, 1'b0, N, 32'h0, 1'b0});

    // Pass-through, fill under stall, drain, flush mid-stream, other stall bits ignored.
    add(0, 0, 0, 0, 0, NS,                          1, 0, N, 0, 0);
    add(1, 32'h00500093, 32'h80000000, 0, 0, NS,    1, 0, N, 0, 0);
    add(0, 0, 0, 0, 0, NS,                          1, 1, 32'h00500093, 32'h80000000, 0);
    add(0, 0, 0, 0, 0, NS,                          1, 0, N, 0, 0);
    add(1, 32'h00000093, 32'h80000000, 0, 0, ST,    1, 0, N, 0, 0);
    add(1, 32'h00400093, 32'h80000004, 0, 0, ST,    1, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h00800093, 32'h80000008, 1, 0, ST,    1, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h00c00093, 32'h8000000C, 0, 0, ST,    1, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h01000093, 32'h80000010, 1, 0, ST,    0, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h01000093, 32'h80000010, 1, 0, ST,    0, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h01000093, 32'h80000010, 1, 0, NS,    0, 1, 32'h00000093, 32'h80000000, 0);
    add(1, 32'h01000093, 32'h80000010, 1, 0, NS,    1, 1, 32'h00400093, 32'h80000004, 0);
    add(0, 0, 0, 0, 0, NS,                          1, 1, 32'h00800093, 32'h80000008, 1);
    add(0, 0, 0, 0, 0, NS,                          1, 1, 32'h00c00093, 32'h8000000C, 0);
    add(0, 0, 0, 0, 0, NS,                          1, 1, 32'h01000093, 32'h80000010, 1);
    add(0, 0, 0, 0, 0, NS,                          1, 0, N, 0, 0);
    add(1, 32'h10000093, 32'h80000100, 0, 0, ST,    1, 0, N, 0, 0);
    add(1, 32'h10400093, 32'h80000104, 1, 0, ST,    1, 1, 32'h10000093, 32'h80000100, 0);
    add(1, 32'h10800093, 32'h80000108, 0, 0, ST,    1, 1, 32'h10000093, 32'h80000100, 0);
    add(1, 32'h10c00093, 32'h8000010C, 1, 1, ST,    1, 1, 32'h10000093, 32'h80000100, 0);
    add(0, 0, 0, 0, 0, NS,                          1, 0, N, 0, 0);
    add(1, 32'h02a00093, 32'h80001000, 1, 0, NS,    1, 0, N, 0, 0);
    add(0, 0, 0, 0, 0, OT,                          1, 1, 32'h02a00093, 32'h80001000, 1);
    add(0, 0, 0, 0, 0, NS,                          1, 0, N, 0, 0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fv, vecs[i].inst, vecs[i].addr, vecs[i].pred, vecs[i].flush, vecs[i].stall);
      #1;
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
      @(negedge clk);
    end

    // Wrap-around stream: pred toggles, stall on every other cycle, queue model.
    sent = 0;
    for (int cyc = 0; cyc < 40 && (sent < 10 || q.size() != 0); cyc++) begin
      nxt.addr = 32'h80002000 + 32'(sent * 4);
      nxt.inst = 32'h00000093 + 32'(sent << 20);
      nxt.pred = sent[0];
      drive(sent < 10, nxt.inst, nxt.addr, nxt.pred, 0, (cyc % 2 == 0) ? ST : NS);
      #1;
      if (q.size() != 0) begin
        hd  = q[0];
        exp = {q.size() != 4, 1'b1, hd.inst, hd.addr, hd.pred};
      end else begin
        exp = {1'b1, 1'b0, N, 32'h0, 1'b0};
      end
      check($sformatf("wrap%0d", cyc), observed(), exp);
      push_m = fetch_valid && (q.size() < 4);
      pop_m  = (q.size() != 0) && !stall_flag[1];
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(nxt);
        sent++;
      end
      @(negedge clk);
    end
    check("wrap_done", {35'h0, 32'(sent), q.size() == 0 ? 32'h0 : 32'h1}, {35'h0, 32'd10, 32'h0});

    // Fill under stall, then assert reset between clock edges.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h20000093 + 32'(i << 20), 32'h80003000 + 32'(i * 4), 1, 0, ST);
      @(negedge clk);
    end
    drive(0, '0, '0, 0, 0, ST);
    #1;
    check("full_before_reset", observed(), {1'b0, 1'b1, 32'h20000093, 32'h80003000, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), {1'b1, 1'b0, N, 32'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, '0, '0, 0, 0, NS);
    #1;
    check("after_reset", observed(), {1'b1, 1'b0, N, 32'h0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
